// File: rtl/sc_poscompare_scheduler.sv
// Frame-level scheduler that shares one position comparator between two players,
// tracks hits and lives, freezes play after a hit and latches game over.
module sc_poscompare_scheduler #(
    parameter int DATAWIDTH     = 8,
    parameter int LIVES_W       = 2,
    parameter int INIT_LIVES    = 3,
    parameter int CNT_W         = 26,
    parameter int FREEZE_CYCLES = 4
) (
    input  logic                 SC_POSSCHED_CLOCK_50,
    input  logic                 SC_POSSCHED_RESET_InHigh,
    input  logic                 SC_POSSCHED_frame_InHigh,
    input  logic                 SC_POSSCHED_enjug2,
    input  logic [DATAWIDTH-1:0] SC_POSSCHED_fila0,
    input  logic [DATAWIDTH-1:0] SC_POSSCHED_posjug1,
    input  logic [DATAWIDTH-1:0] SC_POSSCHED_posjug2,
    output logic [DATAWIDTH-1:0] SC_POSSCHED_cmp_fila,
    output logic [DATAWIDTH-1:0] SC_POSSCHED_cmp_pos,
    input  logic                 SC_POSSCHED_cmp_result,
    output logic                 SC_POSSCHED_busy,
    output logic                 SC_POSSCHED_done,
    output logic                 SC_POSSCHED_hit1,
    output logic                 SC_POSSCHED_hit2,
    output logic [LIVES_W-1:0]   SC_POSSCHED_lives1,
    output logic [LIVES_W-1:0]   SC_POSSCHED_lives2,
    output logic                 SC_POSSCHED_gameover,
    output logic                 SC_POSSCHED_overrun
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMP1   = 3'd1,
        S_CMP2   = 3'd2,
        S_UPDATE = 3'd3,
        S_FREEZE = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = {{(LIVES_W-1){1'b0}}, 1'b1};
    localparam logic [LIVES_W-1:0] LIVES_ZERO = {LIVES_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(FREEZE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [DATAWIDTH-1:0] BUS_ZERO = {DATAWIDTH{1'b0}};

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_snap_fila;
    logic [DATAWIDTH-1:0] r_snap_pos1;
    logic [DATAWIDTH-1:0] r_snap_pos2;
    logic                 r_snap_en2;
    logic [DATAWIDTH-1:0] r_cmp_fila;
    logic [DATAWIDTH-1:0] r_cmp_pos;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_hit1;
    logic                 r_hit2;
    logic [LIVES_W-1:0]   r_lives1;
    logic [LIVES_W-1:0]   r_lives2;
    logic                 r_gameover;
    logic                 r_overrun;
    logic [CNT_W-1:0]     r_cnt;

    logic [LIVES_W-1:0]   w_lives1_dec;
    logic [LIVES_W-1:0]   w_lives2_dec;
    logic                 w_over;
    logic                 w_any_hit;

    // Saturating lives update and end-of-game decision evaluated in UPDATE
    always_comb begin
        w_lives1_dec = r_lives1;
        w_lives2_dec = r_lives2;
        if (r_hit1 && (r_lives1 != LIVES_ZERO)) begin
            w_lives1_dec = r_lives1 - LIVES_ONE;
        end else begin
            w_lives1_dec = r_lives1;
        end
        if (r_hit2 && (r_lives2 != LIVES_ZERO)) begin
            w_lives2_dec = r_lives2 - LIVES_ONE;
        end else begin
            w_lives2_dec = r_lives2;
        end
        w_over    = (w_lives1_dec == LIVES_ZERO) ||
                    (r_snap_en2 && (w_lives2_dec == LIVES_ZERO));
        w_any_hit = r_hit1 || r_hit2;
    end

    // Frame evaluation FSM; comparator drive is registered one state ahead
    always_ff @(posedge SC_POSSCHED_CLOCK_50) begin
        if (SC_POSSCHED_RESET_InHigh) begin
            r_state     <= S_IDLE;
            r_snap_fila <= BUS_ZERO;
            r_snap_pos1 <= BUS_ZERO;
            r_snap_pos2 <= BUS_ZERO;
            r_snap_en2  <= 1'b0;
            r_cmp_fila  <= BUS_ZERO;
            r_cmp_pos   <= BUS_ZERO;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hit1      <= 1'b0;
            r_hit2      <= 1'b0;
            r_lives1    <= LIVES_INIT;
            r_lives2    <= LIVES_INIT;
            r_gameover  <= 1'b0;
            r_overrun   <= 1'b0;
            r_cnt       <= CNT_ZERO;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (SC_POSSCHED_frame_InHigh) begin
                        r_snap_fila <= SC_POSSCHED_fila0;
                        r_snap_pos1 <= SC_POSSCHED_posjug1;
                        r_snap_pos2 <= SC_POSSCHED_posjug2;
                        r_snap_en2  <= SC_POSSCHED_enjug2;
                        r_cmp_fila  <= SC_POSSCHED_fila0;
                        r_cmp_pos   <= SC_POSSCHED_posjug1;
                        r_hit1      <= 1'b0;
                        r_hit2      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_CMP1;
                    end
                end
                S_CMP1: begin
                    r_hit1 <= ~SC_POSSCHED_cmp_result;
                    if (SC_POSSCHED_frame_InHigh) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_snap_en2) begin
                        r_cmp_fila <= r_snap_fila;
                        r_cmp_pos  <= r_snap_pos2;
                        r_state    <= S_CMP2;
                    end else begin
                        r_cmp_fila <= BUS_ZERO;
                        r_cmp_pos  <= BUS_ZERO;
                        r_state    <= S_UPDATE;
                    end
                end
                S_CMP2: begin
                    r_hit2     <= ~SC_POSSCHED_cmp_result;
                    r_cmp_fila <= BUS_ZERO;
                    r_cmp_pos  <= BUS_ZERO;
                    if (SC_POSSCHED_frame_InHigh) begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_lives1 <= w_lives1_dec;
                    r_lives2 <= w_lives2_dec;
                    if (SC_POSSCHED_frame_InHigh) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_over) begin
                        r_gameover <= 1'b1;
                        r_done     <= 1'b1;
                        r_state    <= S_OVER;
                    end else if (w_any_hit) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_FREEZE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_FREEZE: begin
                    if (SC_POSSCHED_frame_InHigh) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_cnt == CNT_ZERO) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_OVER: begin
                    // Terminal: ticks are dropped silently until reset
                    r_busy     <= 1'b1;
                    r_gameover <= 1'b1;
                    r_state    <= S_OVER;
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_cmp_fila <= BUS_ZERO;
                    r_cmp_pos  <= BUS_ZERO;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign SC_POSSCHED_cmp_fila = r_cmp_fila;
    assign SC_POSSCHED_cmp_pos  = r_cmp_pos;
    assign SC_POSSCHED_busy     = r_busy;
    assign SC_POSSCHED_done     = r_done;
    assign SC_POSSCHED_hit1     = r_hit1;
    assign SC_POSSCHED_hit2     = r_hit2;
    assign SC_POSSCHED_lives1   = r_lives1;
    assign SC_POSSCHED_lives2   = r_lives2;
    assign SC_POSSCHED_gameover = r_gameover;
    assign SC_POSSCHED_overrun  = r_overrun;

endmodule

// File: tb/tb_sc_poscompare_scheduler.sv
// Directed bench for sc_poscompare_scheduler: vector table for whole frames plus
// hand sequences for overrun, reset during FREEZE and game over.
module tb_sc_poscompare_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame;
    logic       en2;
    logic [7:0] fila;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [7:0] cmp_fila;
    logic [7:0] cmp_pos;
    logic       cmp_result;
    logic       busy;
    logic       done;
    logic       hit1;
    logic       hit2;
    logic [1:0] lives1;
    logic [1:0] lives2;
    logic       gameover;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    logic [7:0] cur_p2;
    logic       cur_en2;

    always #5 clk = ~clk;

    // Shared comparator model: 0 when the row overlaps the position
    assign cmp_result = ((cmp_fila & cmp_pos) == 8'h00) ? 1'b1 : 1'b0;

    sc_poscompare_scheduler dut (
        .SC_POSSCHED_CLOCK_50    (clk),
        .SC_POSSCHED_RESET_InHigh(rst),
        .SC_POSSCHED_frame_InHigh(frame),
        .SC_POSSCHED_enjug2      (en2),
        .SC_POSSCHED_fila0       (fila),
        .SC_POSSCHED_posjug1     (p1),
        .SC_POSSCHED_posjug2     (p2),
        .SC_POSSCHED_cmp_fila    (cmp_fila),
        .SC_POSSCHED_cmp_pos     (cmp_pos),
        .SC_POSSCHED_cmp_result  (cmp_result),
        .SC_POSSCHED_busy        (busy),
        .SC_POSSCHED_done        (done),
        .SC_POSSCHED_hit1        (hit1),
        .SC_POSSCHED_hit2        (hit2),
        .SC_POSSCHED_lives1      (lives1),
        .SC_POSSCHED_lives2      (lives2),
        .SC_POSSCHED_gameover    (gameover),
        .SC_POSSCHED_overrun     (overrun)
    );

    typedef struct {
        logic [7:0] fila;
        logic [7:0] p1;
        logic [7:0] p2;
        logic       en2;
        logic       hit1;
        logic       hit2;
        logic [1:0] lives1;
        logic [1:0] lives2;
        int         lat;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one-cycle frame tick, then scramble inputs to prove the snapshot is used
    task automatic start(input logic [7:0] f, input logic [7:0] a, input logic [7:0] b, input logic e);
        fila = f; p1 = a; p2 = b; en2 = e;
        cur_p2 = b; cur_en2 = e;
        frame = 1'b1;
        step();
        frame = 1'b0;
        fila = ~f; p1 = ~a; p2 = ~b; en2 = ~e;
    endtask

    // Count cycles after the accepting edge until done; lat=1 is the CMP1 cycle
    task automatic wait_done(output int lat, output logic saw_p2);
        lat = 1;
        saw_p2 = 1'b0;
        while (!done && lat < 40) begin
            if (!cur_en2 && cmp_pos == cur_p2) saw_p2 = 1'b1;
            step();
            lat++;
        end
    endtask

    int   lat;
    logic saw;

    initial begin
        rst = 1'b1; frame = 1'b0; en2 = 1'b0; fila = 8'h00; p1 = 8'h00; p2 = 8'h00;
        vecs[0] = '{8'h18, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 4};
        vecs[1] = '{8'h18, 8'h08, 8'h80, 1'b1, 1'b1, 1'b0, 2'd2, 2'd3, 8};
        vecs[2] = '{8'h18, 8'h01, 8'h18, 1'b0, 1'b0, 1'b0, 2'd2, 2'd3, 3};
        vecs[3] = '{8'h18, 8'h10, 8'h18, 1'b0, 1'b1, 1'b0, 2'd1, 2'd3, 7};

        step(); step();
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_lives", {lives1, lives2}, 4'hF);
        chk("rst_flags", {hit1, hit2, gameover, overrun}, 4'h0);
        chk("rst_cmp", {cmp_fila, cmp_pos}, 16'h0000);

        for (int i = 0; i < 4; i++) begin
            start(vecs[i].fila, vecs[i].p1, vecs[i].p2, vecs[i].en2);
            chk($sformatf("v%0d_busy_t1", i), busy, 1'b1);
            chk($sformatf("v%0d_cmp_pos_t1", i), cmp_pos, vecs[i].p1);
            wait_done(lat, saw);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_done", i), busy, 1'b0);
            chk($sformatf("v%0d_hits", i), {hit1, hit2}, {vecs[i].hit1, vecs[i].hit2});
            chk($sformatf("v%0d_lives", i), {lives1, lives2}, {vecs[i].lives1, vecs[i].lives2});
            if (!vecs[i].en2) chk($sformatf("v%0d_no_pos2", i), saw, 1'b0);
            step();
            chk($sformatf("v%0d_done_pulse", i), done, 1'b0);
            chk($sformatf("v%0d_hit1_hold", i), hit1, vecs[i].hit1);
        end

        // Extra tick at t+2 sets overrun; tick on the done cycle is accepted
        start(8'h18, 8'h01, 8'h80, 1'b1);
        step();
        frame = 1'b1;
        step();
        frame = 1'b0;
        step();
        chk("ovr_done_t4", done, 1'b1);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_lives", {lives1, lives2}, 4'h7);
        start(8'h18, 8'h01, 8'h80, 1'b1);
        chk("ovr_accept_busy", busy, 1'b1);
        wait_done(lat, saw);
        chk("ovr_accept_lat", lat, 4);
        chk("ovr_sticky", overrun, 1'b1);

        // Reset during FREEZE together with a tick
        rst = 1'b1; step(); rst = 1'b0;
        start(8'h18, 8'h08, 8'h80, 1'b1);
        for (int k = 0; k < 4; k++) step();
        chk("frz_busy", busy, 1'b1);
        rst = 1'b1; frame = 1'b1;
        step();
        rst = 1'b0; frame = 1'b0;
        chk("frz_rst_busy", busy, 1'b0);
        chk("frz_rst_lives", {lives1, lives2}, 4'hF);
        chk("frz_rst_flags", {done, hit1, hit2, gameover, overrun}, 5'h00);
        step();
        chk("frz_tick_dropped", busy, 1'b0);

        // Simultaneous hits for three frames lead to game over
        for (int f = 0; f < 2; f++) begin
            start(8'h18, 8'h08, 8'h10, 1'b1);
            wait_done(lat, saw);
            chk($sformatf("both%0d_lat", f), lat, 8);
            chk($sformatf("both%0d_lives", f), {lives1, lives2}, (f == 0) ? 4'hA : 4'h5);
            chk($sformatf("both%0d_hits", f), {hit1, hit2}, 2'b11);
        end
        start(8'h18, 8'h08, 8'h10, 1'b1);
        wait_done(lat, saw);
        chk("over_lat", lat, 4);
        chk("over_gameover", gameover, 1'b1);
        chk("over_lives", {lives1, lives2}, 4'h0);
        chk("over_busy", busy, 1'b1);
        frame = 1'b1;
        step();
        frame = 1'b0;
        chk("over_done_once", done, 1'b0);
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done) saw = 1'b1;
            step();
        end
        chk("over_no_done", saw, 1'b0);
        chk("over_no_overrun", overrun, 1'b0);
        chk("over_sticky", {gameover, busy}, 2'b11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
